// File: rtl/count_source.sv
// Two-button debounced up/down counter, 0..MAX_COUNT with wrap-around pulse.
// Optional feature macro: AUTO_REPEAT_EN (held button auto-repeats steps).
module count_source #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int MAX_COUNT       = 999,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       en,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [9:0] DataOut,
   output logic       wrap
);

   localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0]        MAX_VAL = 10'(MAX_COUNT);
`ifdef AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   logic [1:0] raw;
   logic [1:0] step;

   assign raw = {btn_dec, btn_inc};

   // Bit 0 is the increment button, bit 1 the decrement button.
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic            sync1;
      logic            sync2;
      db_state_t       state;
      db_state_t       state_nx;
      logic [DB_W-1:0] cnt;
      logic [DB_W-1:0] cnt_nx;
      logic            press_step;
      logic            rep_step;

      always_ff @(posedge clk_50M or posedge rst) begin
         if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
         end else begin
            sync1 <= raw[b];
            sync2 <= sync1;
         end
      end

      always_ff @(posedge clk_50M or posedge rst) begin
         if (rst) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
         end
      end

      // Stability counter is cleared on every state change or level flip.
      always_comb begin
         state_nx = state;
         cnt_nx   = '0;
         case (state)
            IDLE: begin
               if (sync2) state_nx = PRESS_WAIT;
               else       state_nx = IDLE;
            end
            PRESS_WAIT: begin
               if (!sync2)               state_nx = IDLE;
               else if (cnt == DB_LAST)  state_nx = PRESSED;
               else                      cnt_nx   = cnt + DB_W'(1);
            end
            PRESSED: begin
               if (!sync2) state_nx = RELEASE_WAIT;
               else        state_nx = PRESSED;
            end
            RELEASE_WAIT: begin
               if (sync2)                state_nx = PRESSED;
               else if (cnt == DB_LAST)  state_nx = IDLE;
               else                      cnt_nx   = cnt + DB_W'(1);
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end

      always_comb begin
         press_step = (state == PRESS_WAIT) && sync2 && (cnt == DB_LAST);
      end

`ifdef AUTO_REPEAT_EN
      logic [RP_W-1:0] rcnt;
      logic            repeating;

      always_comb begin
         rep_step = (state == PRESSED) && sync2 &&
                    (rcnt == (repeating ? RP_LAST : RD_LAST));
      end

      // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
      always_ff @(posedge clk_50M or posedge rst) begin
         if (rst) begin
            rcnt      <= '0;
            repeating <= 1'b0;
         end else if (state != PRESSED) begin
            rcnt      <= '0;
            repeating <= 1'b0;
         end else if (rep_step) begin
            rcnt      <= '0;
            repeating <= 1'b1;
         end else begin
            rcnt      <= rcnt + RP_W'(1);
            repeating <= repeating;
         end
      end
`else
      assign rep_step = 1'b0;
`endif

      assign step[b] = press_step | rep_step;
   end

   // Opposing steps in one cycle cancel; steps with en low are dropped.
   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         DataOut <= 10'd0;
         wrap    <= 1'b0;
      end else if (en && step[0] && !step[1]) begin
         if (DataOut >= MAX_VAL) begin
            DataOut <= 10'd0;
            wrap    <= 1'b1;
         end else begin
            DataOut <= DataOut + 10'd1;
            wrap    <= 1'b0;
         end
      end else if (en && step[1] && !step[0]) begin
         if (DataOut == 10'd0) begin
            DataOut <= MAX_VAL;
            wrap    <= 1'b1;
         end else begin
            DataOut <= DataOut - 10'd1;
            wrap    <= 1'b0;
         end
      end else begin
         DataOut <= DataOut;
         wrap    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_count_source.sv
// Scoreboard bench for count_source: expected DataOut/wrap events (with the
// clock edge they must land on) are queued at stimulus time and popped on change.
module tb_count_source;

   localparam int DB  = 4;
   localparam int MAX = 9;
`ifdef AUTO_REPEAT_EN
   localparam int HOLD1 = 8;
`else
   localparam int HOLD1 = 20;
`endif

   logic       clk_50M = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b1;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic [9:0] DataOut;
   logic       wrap;

   typedef struct {
      int         cyc;
      logic [9:0] data;
      logic       wrap;
   } exp_t;

   exp_t       sb[$];
   int         cyc   = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [9:0] model = 10'd0;
   logic [9:0] prev  = 10'd0;

   count_source #(
      .DEBOUNCE_CYCLES(DB),
      .MAX_COUNT      (MAX),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) dut (
      .clk_50M(clk_50M),
      .rst    (rst),
      .en     (en),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .DataOut(DataOut),
      .wrap   (wrap)
   );

   always #5 clk_50M = ~clk_50M;

   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [9:0] d, input logic w);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      e.wrap = w;
      sb.push_back(e);
   endtask

   // Monitor: every DataOut change or wrap pulse must match the queue head.
   always @(negedge clk_50M) begin
      if (rst) begin
         prev = DataOut;
      end else if (DataOut !== prev || wrap !== 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_evt", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("evt_cyc", cyc, e.cyc);
            check("evt_data", DataOut, e.data);
            check("evt_wrap", wrap, e.wrap);
         end
         prev = DataOut;
      end
   end

   task automatic do_press(input bit inc, input bit dec, input int hold);
      int         c;
      logic [9:0] nm;
      logic       w;
      c  = cyc;
      nm = model;
      w  = 1'b0;
      if (en && inc && !dec) begin
         if (model == 10'(MAX)) begin nm = 10'd0; w = 1'b1; end
         else nm = model + 10'd1;
      end else if (en && dec && !inc) begin
         if (model == 10'd0) begin nm = 10'(MAX); w = 1'b1; end
         else nm = model - 10'd1;
      end
      if (nm != model || w) push(c + DB + 3, nm, w);
      model   = nm;
      btn_inc = inc;
      btn_dec = dec;
      repeat (hold) @(negedge clk_50M);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      repeat (12) @(negedge clk_50M);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      repeat (3) @(negedge clk_50M);
      check("rst_data", DataOut, 0);
      check("rst_wrap", wrap, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk_50M);

      // Clean press: one step after DB+3 edges, nothing further.
      do_press(1'b1, 1'b0, HOLD1);
      check("clean_press", DataOut, 1);

      // Bouncing input never stable long enough.
      for (int i = 0; i < 15; i++) begin
         btn_inc = ~btn_inc;
         repeat (2) @(negedge clk_50M);
      end
      btn_inc = 1'b0;
      repeat (12) @(negedge clk_50M);
      check("bounce", DataOut, 1);

      // Climb to MAX, then wrap up and back down.
      for (int i = 0; i < MAX - 1; i++) do_press(1'b1, 1'b0, 8);
      check("at_max", DataOut, MAX);
      do_press(1'b1, 1'b0, 8);
      check("wrap_up", DataOut, 0);
      do_press(1'b0, 1'b1, 8);
      check("wrap_down", DataOut, MAX);

      // Simultaneous presses cancel.
      do_press(1'b1, 1'b1, 8);
      check("simul", DataOut, MAX);

      // Steps while disabled are discarded.
      en = 1'b0;
      do_press(1'b1, 1'b0, 8);
      en = 1'b1;
      repeat (4) @(negedge clk_50M);
      check("en_low", DataOut, MAX);
      do_press(1'b0, 1'b1, 8);
      check("after_en", DataOut, MAX - 1);

      // Reset two cycles into PRESS_WAIT with the button held.
      btn_inc = 1'b1;
      repeat (5) @(negedge clk_50M);
      rst = 1'b1;
      repeat (2) @(negedge clk_50M);
      check("rst_mid_data", DataOut, 0);
      check("rst_mid_wrap", wrap, 0);
      model = 10'd1;
      c = cyc;
      push(c + DB + 3, 10'd1, 1'b0);
      rst = 1'b0;
      repeat (12) @(negedge clk_50M);
      btn_inc = 1'b0;
      repeat (12) @(negedge clk_50M);
      check("rst_repress", DataOut, 1);

`ifdef AUTO_REPEAT_EN
      do_press(1'b0, 1'b1, 8);
      check("rep_start", DataOut, 0);
      c = cyc;
      push(c + 7, 10'd1, 1'b0);
      push(c + 17, 10'd2, 1'b0);
      push(c + 20, 10'd3, 1'b0);
      push(c + 23, 10'd4, 1'b0);
      push(c + 26, 10'd5, 1'b0);
      push(c + 29, 10'd6, 1'b0);
      btn_inc = 1'b1;
      repeat (29) @(negedge clk_50M);
      btn_inc = 1'b0;
      repeat (15) @(negedge clk_50M);
      check("repeat", DataOut, 6);
`endif

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
